// File: rtl/i2c_pkg.sv
// Shared definitions for the single-wire I2C-style initiator and its slave.
package i2c_pkg;

    localparam int unsigned I2C_BYTE_W = 8;
    localparam int unsigned I2C_CNT_W  = 3;

    localparam logic RW_WRITE    = 1'b0;
    localparam logic RW_READ     = 1'b1;
    localparam logic ACK         = 1'b0;
    localparam logic CONT_WRITE  = 1'b1;
    localparam logic CONT_RSTART = 1'b0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_DEV_ADDR,
        ST_DEV_ACK,
        ST_REG_ADDR,
        ST_REG_ACK,
        ST_CONT,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDEV_ADDR,
        ST_RDEV_ACK,
        ST_RDATA,
        ST_STOP0,
        ST_STOP1
    } i2c_state_e;

    // ACK slot that follows each master-driven byte field
    function automatic i2c_state_e ack_after(input i2c_state_e s);
        i2c_state_e r;
        case (s)
            ST_DEV_ADDR:  r = ST_DEV_ACK;
            ST_REG_ADDR:  r = ST_REG_ACK;
            ST_WDATA:     r = ST_WDATA_ACK;
            ST_RDEV_ADDR: r = ST_RDEV_ACK;
            default:      r = ST_STOP0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/i2c_shifter.sv
// Byte register shared by every field: parallel load, MSB-first shift with
// serial in, and a down-counter flagging the last bit of the field.
module i2c_shifter
    import i2c_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  shift,
    input  logic [I2C_BYTE_W-1:0] load_data,
    input  logic                  sin,
    output logic [I2C_BYTE_W-1:0] data,
    output logic                  last_bit
);

    logic [I2C_BYTE_W-1:0] data_q, data_d;
    logic [I2C_CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (load) begin
            data_d = load_data;
            cnt_d  = I2C_CNT_W'(I2C_BYTE_W - 1);
        end else if (shift) begin
            data_d = {data_q[I2C_BYTE_W-2:0], sin};
            cnt_d  = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign data     = data_q;
    assign last_bit = (cnt_q == '0);

endmodule

// File: rtl/i2c_master.sv
// Initiator for the clk-synchronous single-wire register bus: one bus bit per
// clk, register write or register read (write pointer, repeated start, read).
module i2c_master
    import i2c_pkg::*;
#(
    parameter int unsigned DEV_ADDR_W = 7,
    parameter int unsigned REG_ADDR_W = 8,
    parameter int unsigned DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    inout  wire                   sda,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_rw,
    input  logic [DEV_ADDR_W-1:0] cmd_dev_addr,
    input  logic [REG_ADDR_W-1:0] cmd_reg_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_nack,
    output logic                  busy
);

    i2c_state_e state_q, state_d;

    logic                  rw_q, rw_d;
    logic [DEV_ADDR_W-1:0] dev_q, dev_d;
    logic [REG_ADDR_W-1:0] reg_q, reg_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  nack_q, nack_d;
    logic                  sda_oe_q, sda_oe_d;
    logic                  sda_out_q, sda_out_d;
    logic                  busy_q, busy_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_nack_q, rsp_nack_d;

    logic                  sh_load_c;
    logic                  sh_shift_c;
    logic [I2C_BYTE_W-1:0] sh_load_data_c;
    logic [I2C_BYTE_W-1:0] sh_data;
    logic                  sh_last;
    logic                  sda_in_c;

    // Only a sampled 0 counts as a 0 bit or an ACK; released bus reads as 1
    assign sda_in_c = (sda == 1'b0) ? 1'b0 : 1'b1;
    assign sda      = sda_oe_q ? sda_out_q : 1'bz;

    i2c_shifter u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (sh_load_c),
        .shift     (sh_shift_c),
        .load_data (sh_load_data_c),
        .sin       (sda_in_c),
        .data      (sh_data),
        .last_bit  (sh_last)
    );

    // sda_*_d always describes the wire for the cycle after this edge
    always_comb begin
        state_d        = state_q;
        rw_d           = rw_q;
        dev_d          = dev_q;
        reg_d          = reg_q;
        wdata_d        = wdata_q;
        nack_d         = nack_q;
        sda_oe_d       = 1'b0;
        sda_out_d      = 1'b1;
        rsp_valid_d    = 1'b0;
        rsp_rdata_d    = rsp_rdata_q;
        rsp_nack_d     = rsp_nack_q;
        sh_load_c      = 1'b0;
        sh_shift_c     = 1'b0;
        sh_load_data_c = '0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    rw_d      = cmd_rw;
                    dev_d     = cmd_dev_addr;
                    reg_d     = cmd_reg_addr;
                    wdata_d   = cmd_wdata;
                    nack_d    = 1'b0;
                    state_d   = ST_START;
                    sda_oe_d  = 1'b1;
                    sda_out_d = 1'b0;
                end
            end
            ST_START: begin
                sh_load_c      = 1'b1;
                sh_load_data_c = I2C_BYTE_W'({dev_q, RW_WRITE});
                state_d        = ST_DEV_ADDR;
                sda_oe_d       = 1'b1;
                sda_out_d      = sh_load_data_c[I2C_BYTE_W-1];
            end
            ST_DEV_ADDR, ST_REG_ADDR, ST_WDATA, ST_RDEV_ADDR: begin
                sh_shift_c = 1'b1;
                if (sh_last) begin
                    state_d = ack_after(state_q);
                end else begin
                    sda_oe_d  = 1'b1;
                    sda_out_d = sh_data[I2C_BYTE_W-2];
                end
            end
            ST_DEV_ACK, ST_REG_ACK, ST_RDEV_ACK: begin
                sda_oe_d = 1'b1;
                if (sda_in_c != ACK) begin
                    nack_d    = 1'b1;
                    state_d   = ST_STOP0;
                    sda_out_d = 1'b0;
                end else if (state_q == ST_DEV_ACK) begin
                    sh_load_c      = 1'b1;
                    sh_load_data_c = I2C_BYTE_W'(reg_q);
                    state_d        = ST_REG_ADDR;
                    sda_out_d      = sh_load_data_c[I2C_BYTE_W-1];
                end else if (state_q == ST_REG_ACK) begin
                    state_d   = ST_CONT;
                    sda_out_d = (rw_q == RW_READ) ? CONT_RSTART : CONT_WRITE;
                end else begin
                    sh_load_c = 1'b1;
                    state_d   = ST_RDATA;
                    sda_oe_d  = 1'b0;
                end
            end
            ST_CONT: begin
                sh_load_c      = 1'b1;
                sh_load_data_c = (rw_q == RW_READ) ? I2C_BYTE_W'({dev_q, RW_READ})
                                                   : I2C_BYTE_W'(wdata_q);
                state_d        = (rw_q == RW_READ) ? ST_RDEV_ADDR : ST_WDATA;
                sda_oe_d       = 1'b1;
                sda_out_d      = sh_load_data_c[I2C_BYTE_W-1];
            end
            ST_WDATA_ACK: begin
                nack_d    = nack_q | (sda_in_c != ACK);
                state_d   = ST_STOP0;
                sda_oe_d  = 1'b1;
                sda_out_d = 1'b0;
            end
            ST_RDATA: begin
                sh_shift_c = 1'b1;
                if (sh_last) begin
                    state_d   = ST_STOP0;
                    sda_oe_d  = 1'b1;
                    sda_out_d = 1'b0;
                end
            end
            ST_STOP0: begin
                state_d   = ST_STOP1;
                sda_oe_d  = 1'b1;
                sda_out_d = 1'b1;
            end
            ST_STOP1: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b1;
                rsp_nack_d  = nack_q;
                rsp_rdata_d = (rw_q == RW_READ && !nack_q) ? DATA_W'(sh_data) : '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d      = (state_d != ST_IDLE);
        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rw_q        <= RW_WRITE;
            dev_q       <= '0;
            reg_q       <= '0;
            wdata_q     <= '0;
            nack_q      <= 1'b0;
            sda_oe_q    <= 1'b0;
            sda_out_q   <= 1'b1;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_nack_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rw_q        <= rw_d;
            dev_q       <= dev_d;
            reg_q       <= reg_d;
            wdata_q     <= wdata_d;
            nack_q      <= nack_d;
            sda_oe_q    <= sda_oe_d;
            sda_out_q   <= sda_out_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_nack_q  <= rsp_nack_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_nack  = rsp_nack_q;

endmodule

// File: tb/tb_i2c_master.sv
// Scoreboard bench for i2c_master: a scripted bench slave drives ACK/read bits
// and the expected wire, while a separate monitor checks every response strobe.
module tb_i2c_master;

    localparam int REL = 0;
    localparam int D0  = 1;
    localparam int D1  = 2;

    typedef struct {
        logic       nack;
        logic [7:0] rdata;
        int         len;
    } rsp_t;

    logic       clk = 1'b0;
    logic       rst;
    wire        sda;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rw;
    logic [6:0] cmd_dev_addr;
    logic [7:0] cmd_reg_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_nack;
    logic       busy;
    logic       slv_oe;
    logic       slv_out;

    rsp_t exp_rsp[$];
    int   drv_q[$];
    int   bus_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_acc = 0;

    pullup (sda);
    assign sda = (slv_oe && !rst) ? slv_out : 1'bz;

    always #5 clk = ~clk;

    i2c_master dut (
        .clk          (clk),
        .rst          (rst),
        .sda          (sda),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_rw       (cmd_rw),
        .cmd_dev_addr (cmd_dev_addr),
        .cmd_reg_addr (cmd_reg_addr),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_nack     (rsp_nack),
        .busy         (busy)
    );

    always @(posedge clk) begin
        if (!rst && cmd_valid && cmd_ready) n_acc <= n_acc + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_bit(input int b, input int d);
        bus_q.push_back(b);
        drv_q.push_back(d);
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) push_bit(int'(b[i]), REL);
    endtask

    task automatic push_stop();
        push_bit(0, REL);
        push_bit(1, REL);
    endtask

    // Expected bus per cycle plus what the bench slave drives in that cycle.
    // nack_slot: 0 none, 1 dev ack, 2 reg ack, 3 wdata ack, 4 read-dev ack
    task automatic plan(input logic rw, input logic [6:0] dev, input logic [7:0] ra,
                        input logic [7:0] wd, input logic [7:0] rd, input int nack_slot);
        push_bit(0, REL);
        push_byte({dev, 1'b0});
        if (nack_slot == 1) begin push_bit(1, REL); push_stop(); return; end
        push_bit(0, D0);
        push_byte(ra);
        if (nack_slot == 2) begin push_bit(1, REL); push_stop(); return; end
        push_bit(0, D0);
        push_bit(rw ? 0 : 1, REL);
        if (!rw) begin
            push_byte(wd);
            if (nack_slot == 3) push_bit(1, REL);
            else push_bit(0, D0);
        end else begin
            push_byte({dev, 1'b1});
            if (nack_slot == 4) begin push_bit(1, REL); push_stop(); return; end
            push_bit(0, D0);
            for (int i = 7; i >= 0; i--) push_bit(int'(rd[i]), rd[i] ? D1 : D0);
        end
        push_stop();
    endtask

    task automatic issue(input logic rw, input logic [6:0] dev, input logic [7:0] ra,
                         input logic [7:0] wd);
        int waited;
        @(negedge clk);
        cmd_rw       = rw;
        cmd_dev_addr = dev;
        cmd_reg_addr = ra;
        cmd_wdata    = wd;
        cmd_valid    = 1'b1;
        waited       = 0;
        while (!cmd_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_wait", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid    = 1'b0;
        cmd_rw       = ~rw;
        cmd_dev_addr = 7'h7F;
        cmd_reg_addr = 8'hFF;
        cmd_wdata    = 8'hFF;
    endtask

    task automatic wait_done();
        int waited = 0;
        while (exp_rsp.size() != 0 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        chk("rsp_pending", 32'(exp_rsp.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic txn(input logic rw, input logic [6:0] dev, input logic [7:0] ra,
                       input logic [7:0] wd, input logic [7:0] rd, input int nack_slot,
                       input logic e_nack, input logic [7:0] e_rdata, input int e_len);
        plan(rw, dev, ra, wd, rd, nack_slot);
        exp_rsp.push_back('{e_nack, e_rdata, e_len});
        issue(rw, dev, ra, wd);
        wait_done();
    endtask

    // Bench slave: drives its scripted bit each busy cycle and checks the wire
    initial begin
        int d;
        int e;
        slv_oe  = 1'b0;
        slv_out = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                slv_oe = 1'b0;
                drv_q.delete();
                bus_q.delete();
            end else if (busy) begin
                if (drv_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL wire_extra: busy cycle with no scripted bit at %0t", $time);
                end else begin
                    d       = drv_q.pop_front();
                    e       = bus_q.pop_front();
                    slv_oe  = (d != REL);
                    slv_out = (d == D1);
                    #1;
                    chk("wire", 32'(sda), 32'(e));
                    @(posedge clk);
                    #1;
                    slv_oe = 1'b0;
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on every rsp_valid
    initial begin
        int   cyc;
        int   start;
        int   busy_n;
        logic busy_prev;
        rsp_t r;
        cyc       = 0;
        start     = 0;
        busy_n    = 0;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                exp_rsp.delete();
                busy_prev = 1'b0;
                busy_n    = 0;
            end else begin
                if (busy) begin
                    if (!busy_prev) begin
                        start  = cyc;
                        busy_n = 0;
                    end
                    busy_n++;
                end
                busy_prev = busy;
                if (rsp_valid) begin
                    if (exp_rsp.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL rsp_unexpected: rsp_valid with nothing expected at %0t", $time);
                    end else begin
                        r = exp_rsp.pop_front();
                        chk("rsp_nack", 32'(rsp_nack), 32'(r.nack));
                        chk("rsp_rdata", 32'(rsp_rdata), 32'(r.rdata));
                        chk("rsp_cycle", 32'(cyc - start + 1), 32'(r.len + 1));
                        chk("busy_cycles", 32'(busy_n), 32'(r.len));
                        chk("ready_at_rsp", 32'(cmd_ready), 32'd1);
                        chk("busy_at_rsp", 32'(busy), 32'd0);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        int waited;
        rst          = 1'b1;
        cmd_valid    = 1'b0;
        cmd_rw       = 1'b0;
        cmd_dev_addr = '0;
        cmd_reg_addr = '0;
        cmd_wdata    = '0;
        #1;
        chk("reset_sda", 32'(sda), 32'd1);
        chk("reset_ready", 32'(cmd_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_nack", 32'(rsp_nack), 32'd0);
        chk("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        txn(1'b0, 7'h2A, 8'hBE, 8'h5A, 8'h00, 0, 1'b0, 8'h00, 31);
        txn(1'b1, 7'h2A, 8'hBE, 8'h00, 8'h9A, 0, 1'b0, 8'h9A, 39);
        txn(1'b0, 7'h2A, 8'h11, 8'h22, 8'h00, 1, 1'b1, 8'h00, 12);
        txn(1'b0, 7'h2A, 8'hBE, 8'h5A, 8'h00, 3, 1'b1, 8'h00, 31);
        txn(1'b1, 7'h2A, 8'h10, 8'h00, 8'h77, 4, 1'b1, 8'h00, 31);

        // Abort a read in RDATA bit 3 (cycle 34 counting START as 1)
        plan(1'b1, 7'h2A, 8'hBE, 8'h00, 8'hFF, 0);
        exp_rsp.push_back('{1'b0, 8'hFF, 39});
        issue(1'b1, 7'h2A, 8'hBE, 8'h00);
        repeat (34) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_sda", 32'(sda), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(cmd_ready), 32'd1);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        txn(1'b1, 7'h50, 8'h03, 8'h00, 8'hC3, 0, 1'b0, 8'hC3, 39);

        // cmd_valid held high across two back-to-back commands
        plan(1'b0, 7'h11, 8'h22, 8'h33, 8'h00, 0);
        plan(1'b1, 7'h44, 8'h55, 8'h00, 8'hA5, 0);
        exp_rsp.push_back('{1'b0, 8'h00, 31});
        exp_rsp.push_back('{1'b0, 8'hA5, 39});
        acc0 = n_acc;
        issue(1'b0, 7'h11, 8'h22, 8'h33);
        cmd_valid    = 1'b1;
        cmd_rw       = 1'b1;
        cmd_dev_addr = 7'h44;
        cmd_reg_addr = 8'h55;
        cmd_wdata    = 8'hEE;
        waited       = 0;
        while (!rsp_valid && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("hold_first_rsp", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        chk("hold_restart_busy", 32'(busy), 32'd1);
        chk("hold_restart_ready", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0;
        wait_done();
        chk("hold_accepts", 32'(n_acc - acc0), 32'd2);
        chk("plan_drained", 32'(drv_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_master.md
Name: i2c_master

Overview:
- Initiator end of the team's single-wire, clk-synchronous I2C-style link; drives the same `sda` bus that the `slave` block responds on.
- Bit timing is implicit: one bit per `clk` cycle, with no separate SCL.
- Accepts one register-write or register-read command at a time and serialises start, device address, register address, data and stop.
- Returns read data and an ACK-error flag on a one-cycle response strobe.

Parameters:
- DEV_ADDR_W, 7, device address width (followed by the R/W bit on the wire)
- REG_ADDR_W, 8, register address width
- DATA_W, 8, data width

Ports:
- clk  input  1  system clock; one bus bit per cycle
- rst  input  1  reset; asynchronous, active-high
- sda  inout  1  serial data; driven 0/1 or released (z); the bench supplies a pull-up
- cmd_valid  input  1  command request
- cmd_ready  output  1  high in IDLE only
- cmd_rw  input  1  0 = write, 1 = read
- cmd_dev_addr  input  DEV_ADDR_W  target device address
- cmd_reg_addr  input  REG_ADDR_W  target register
- cmd_wdata  input  DATA_W  write data (ignored for read)
- rsp_valid  output  1  one-cycle completion strobe
- rsp_rdata  output  DATA_W  read data; 0 for writes or on NACK
- rsp_nack  output  1  1 if any ACK slot sampled non-zero
- busy  output  1  high from command accept through the last stop cycle

Behaviour:
- Reset (asynchronous):
  - `sda` released immediately; `cmd_ready` = 1.
  - `rsp_valid`, `rsp_rdata`, `rsp_nack`, `busy` = 0; state = IDLE.
  - Reset mid-transfer aborts with no response.
- All state, shift and counter updates occur on posedge `clk`. Driven `sda` values are registered outputs.
- Slave-driven bits are sampled on posedge. Only a sampled 1'b0 counts as ACK or a 0 bit; 1 or z reads as 1.
- Accept: `cmd_valid` && `cmd_ready` at posedge.
  - The command is latched.
  - Next cycle is START; `busy` = 1 and `cmd_ready` = 0.
- States and per-cycle wire content (all shifts MSB first):
  - IDLE: `sda` released.
  - START: drive 0, 1 cycle.
  - DEV_ADDR: 8 cycles; `dev_addr` then R/W bit = 0. The first pass always writes, to set the register pointer.
  - DEV_ACK: release, 1 cycle; sample.
  - REG_ADDR: 8 cycles; `reg_addr`.
  - REG_ACK: release, 1 cycle; sample.
  - CONT: 1 cycle. Drive 1 for a write (continue) or 0 for a read (repeated start).
  - Write path:
    - WDATA: 8 cycles.
    - WDATA_ACK: release, 1 cycle; sample.
    - Then STOP.
  - Read path:
    - RDEV_ADDR: 8 cycles; `dev_addr` then R/W = 1.
    - RDEV_ACK: release, 1 cycle; sample.
    - RDATA: release, 8 cycles; shift the sampled bits in.
    - Then STOP.
  - STOP: drive 0 for 1 cycle, then 1 for 1 cycle; then IDLE, releasing `sda`.
- Totals from the START cycle to the last STOP cycle inclusive: write = 31 cycles, read = 39 cycles.
- Response:
  - `rsp_valid` pulses for 1 cycle in the first IDLE cycle after STOP, with `rsp_nack` and `rsp_rdata` valid there.
  - `rsp_rdata` and `rsp_nack` hold until the next accept.
  - `cmd_ready` returns high in the same cycle as `rsp_valid`.
- NACK (any ACK slot sampled ≠ 0):
  - Skip the remaining fields and go directly to STOP.
  - `rsp_nack` = 1, `rsp_rdata` = 0.
- Bit counter is 3 bits and counts 7 down to 0. Field transition occurs when the count is 0; no wrap is visible externally.
- A `cmd_valid` asserted while `busy` is ignored and is not queued.
- Changes to the command inputs after accept have no effect.

Decomposition:
- Shared package `i2c_pkg`:
  - State enum (IDLE, START, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, CONT, WDATA, WDATA_ACK, RDEV_ADDR, RDEV_ACK, RDATA, STOP0, STOP1).
  - RW_WRITE = 0, RW_READ = 1.
  - ACK = 0, CONT_WRITE = 1, CONT_RSTART = 0.
  - The same package is reused by `slave`.
- One natural sub-module: `i2c_shifter`.
  - 8-bit load / shift-out / shift-in register with bit counter and `last_bit` flag.
  - Instantiated once, shared across all fields.

Test Plan:
- Reset release, then a write: dev 0x2A, reg 0xBE, wdata 0x5A, with a bench slave ACKing every slot.
  - Wire shows 0, 0101010 0, z, 10111110, z, 1, 01011010, z, 0, 1.
  - `rsp_valid` at cycle 32 after START, with `rsp_nack` = 0.
- Read: dev 0x2A, reg 0xBE; bench slave ACKs and returns 0x9A.
  - Wire shows the write preamble, CONT = 0, then 0101010 1, z, then z×8 for data, then stop.
  - `rsp_rdata` = 0x9A and `rsp_valid` at cycle 40.
- No slave present (bus pulled high) on a write.
  - Sequence is START, 8 address bits, DEV_ACK samples 1, then STOP0/STOP1.
  - `rsp_nack` = 1, `rsp_rdata` = 0, after 12 cycles.
- Slave NACKs at WDATA_ACK.
  - The full write frame runs.
  - `rsp_nack` = 1, and `busy` is high for exactly 31 cycles.
- Assert `rst` in RDATA bit 3.
  - `sda` is released within the same time step; `busy` = 0 and `cmd_ready` = 1; no `rsp_valid`.
  - The next command completes normally.
- Hold `cmd_valid` continuously across two commands.
  - Exactly two accepts occur, separated by one `cmd_ready` cycle.
  - The second START follows the first `rsp_valid` by 1 cycle.
